// File: rtl/mask_stack_ctrl.sv
// mask_stack_ctrl: 8x64 LIFO controller over an external register file.
// Defining MASK_STACK_ERR_CHECK_EN adds sticky err_overflow/err_underflow flags.
module mask_stack_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  logic [63:0] push_data,
  output logic        push_ready,
  input  logic        pop_valid,
  output logic        pop_ready,
  output logic [63:0] pop_data,
  output logic        pop_data_valid,
  output logic [3:0]  count,
  output logic        full,
  output logic        empty,
`ifdef MASK_STACK_ERR_CHECK_EN
  output logic        err_overflow,
  output logic        err_underflow,
`endif
  output logic [2:0]  rf_rd_addr,
  input  logic [63:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [63:0] rf_wr_data
);
  logic [2:0] top;
  logic       pop_do;
  logic       push_do;
  assign full       = count == 4'd8;
  assign empty      = count == 4'd0;
  assign top        = count[2:0] - 3'd1;
  assign rf_rd_addr = top;
`ifdef MASK_STACK_ERR_CHECK_EN
  assign push_ready = 1'b1;
  assign pop_ready  = 1'b1;
  assign pop_do     = rst && pop_valid && !empty;
  // a push on full survives only as a replace-top alongside a pop
  assign push_do    = rst && push_valid && (!full || pop_do);
`else
  assign push_ready = !full;
  assign pop_ready  = !empty;
  assign pop_do     = rst && pop_valid && pop_ready;
  assign push_do    = rst && push_valid && push_ready;
`endif
  assign rf_wr_en   = push_do;
  assign rf_wr_addr = pop_do ? top : count[2:0];
  assign rf_wr_data = push_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      count          <= 4'd0;
      pop_data       <= 64'd0;
      pop_data_valid <= 1'b0;
    end else begin
      count          <= count + {3'b0, push_do && !pop_do} - {3'b0, pop_do && !push_do};
      pop_data_valid <= pop_do;
      if (pop_do) pop_data <= rf_rd_data;
    end
  end
`ifdef MASK_STACK_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_valid && full && !pop_do) err_overflow <= 1'b1;
      if (pop_valid && empty) err_underflow <= 1'b1;
    end
  end
`endif
endmodule
